// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// divider latency default and counter sizing.
package hazard_controller_pkg;

   typedef enum logic [0:0] {
      StRun     = 1'b0,
      StDivBusy = 1'b1
   } state_e;

   localparam int unsigned DivLatDefault = 34;
   localparam int unsigned StallCntW    = 32;

   // Down-counter width: large enough to hold DIV_LAT-1
   function automatic int unsigned cnt_width(input int unsigned lat);
      return (lat < 2) ? 1 : $clog2(lat);
   endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Hazard requests from the pipeline and stall/flush/divider controls back to it.
interface hazard_controller_if;
   import hazard_controller_pkg::*;

   logic                 hzd_exe_to_id_A;
   logic                 hzd_mem_to_exe_A;
   logic                 hzd_mem_to_exe_B;
   logic                 exe_is_div;
   logic                 exe_br_taken;

   logic                 stall_if;
   logic                 stall_id;
   logic                 stall_exe;
   logic                 flush_id;
   logic                 flush_exe;
   logic                 flush_mem;
   logic                 div_start;
   logic                 div_busy;
   logic [StallCntW-1:0] stall_cycles;

   // Pipeline side: raises hazards, obeys stalls/flushes
   modport master (
      output hzd_exe_to_id_A, hzd_mem_to_exe_A, hzd_mem_to_exe_B, exe_is_div, exe_br_taken,
      input  stall_if, stall_id, stall_exe, flush_id, flush_exe, flush_mem,
      input  div_start, div_busy, stall_cycles
   );

   // Controller side
   modport slave (
      input  hzd_exe_to_id_A, hzd_mem_to_exe_A, hzd_mem_to_exe_B, exe_is_div, exe_br_taken,
      output stall_if, stall_id, stall_exe, flush_id, flush_exe, flush_mem,
      output div_start, div_busy, stall_cycles
   );

endinterface

// File: rtl/hazard_controller_perf_counter.sv
// Free-running event counter with synchronous active-low reset; wraps at 2^Width.
module hazard_controller_perf_counter #(
   parameter int unsigned Width = 32
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             inc,
   output logic [Width-1:0] count
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc) count_d = count_q + Width'(1);
   end

   always_ff @(posedge clk) begin
      if (!nrst) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, branch flushes and a fixed-latency
// divider stall sequencer, plus a count of front-end stall cycles.
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int unsigned DIV_LAT = DivLatDefault
) (
   input  logic           clk,
   input  logic           nrst,
   hazard_controller_if.slave bus
);

   localparam int unsigned     CntW    = cnt_width(DIV_LAT);
   localparam logic [CntW-1:0] CntLoad = CntW'(DIV_LAT - 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic stall_if, stall_id, stall_exe;
   logic flush_id, flush_exe, flush_mem;
   logic div_start, div_busy;
   logic hzd_mem;
   logic [StallCntW-1:0] stall_cycles;

   assign hzd_mem = bus.hzd_mem_to_exe_A | bus.hzd_mem_to_exe_B;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q <= StRun;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      stall_exe = 1'b0;
      flush_id  = 1'b0;
      flush_exe = 1'b0;
      flush_mem = 1'b0;
      div_start = 1'b0;
      div_busy  = 1'b0;

      // Everything stays quiet while reset is held, even mid-division
      if (nrst) begin
         unique case (state_q)
            StDivBusy: begin
               div_busy = 1'b1;
               if (cnt_q != '0) begin
                  cnt_d     = cnt_q - CntW'(1);
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  stall_exe = 1'b1;
                  flush_mem = 1'b1;
               end else begin
                  // Release cycle: the divide retires, no relaunch possible here
                  state_d = StRun;
               end
            end
            StRun: begin
               if (hzd_mem) begin
                  // Branch operands are not valid yet, so a taken branch waits too
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  stall_exe = 1'b1;
                  flush_mem = 1'b1;
               end else if (bus.exe_br_taken) begin
                  flush_id  = 1'b1;
                  flush_exe = 1'b1;
               end else if (bus.hzd_exe_to_id_A) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  flush_exe = 1'b1;
               end else if (bus.exe_is_div) begin
                  div_start = 1'b1;
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  stall_exe = 1'b1;
                  flush_mem = 1'b1;
                  cnt_d     = CntLoad;
                  state_d   = StDivBusy;
               end
            end
            default: state_d = StRun;
         endcase
      end
   end

   hazard_controller_perf_counter #(
      .Width (StallCntW)
   ) u_perf (
      .clk   (clk),
      .nrst  (nrst),
      .inc   (stall_if),
      .count (stall_cycles)
   );

   assign bus.stall_if     = stall_if;
   assign bus.stall_id     = stall_id;
   assign bus.stall_exe    = stall_exe;
   assign bus.flush_id     = flush_id;
   assign bus.flush_exe    = flush_exe;
   assign bus.flush_mem    = flush_mem;
   assign bus.div_start    = div_start;
   assign bus.div_busy     = div_busy;
   assign bus.stall_cycles = stall_cycles;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with a 4-cycle divider.
module tb_hazard_controller;

   logic clk;
   logic nrst;
   int   errors;
   int   checks;

   hazard_controller_if bus ();

   hazard_controller #(
      .DIV_LAT (4)
   ) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output order: stall_if stall_id stall_exe flush_id flush_exe flush_mem div_start div_busy
   localparam logic [7:0] Idle    = 8'h00;
   localparam logic [7:0] LdStall = 8'hE4;
   localparam logic [7:0] BrFlush = 8'h18;
   localparam logic [7:0] IdStall = 8'hC8;
   localparam logic [7:0] DivGo   = 8'hE6;
   localparam logic [7:0] DivHold = 8'hE5;
   localparam logic [7:0] DivRel  = 8'h01;

   // in order: exe_to_id_A mem_to_exe_A mem_to_exe_B exe_is_div br_taken
   task automatic cyc(input logic rst_n, input logic [4:0] in, input logic [7:0] exp,
                      input string tag);
      logic [7:0] obs;
      @(negedge clk);
      nrst                 = rst_n;
      bus.hzd_exe_to_id_A  = in[4];
      bus.hzd_mem_to_exe_A = in[3];
      bus.hzd_mem_to_exe_B = in[2];
      bus.exe_is_div       = in[1];
      bus.exe_br_taken     = in[0];
      #1;
      obs = {bus.stall_if, bus.stall_id, bus.stall_exe, bus.flush_id, bus.flush_exe,
             bus.flush_mem, bus.div_start, bus.div_busy};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_cnt(input logic [31:0] exp, input string tag);
      checks++;
      assert (bus.stall_cycles === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, bus.stall_cycles, exp);
      end
   endtask

   initial begin
      errors               = 0;
      checks               = 0;
      nrst                 = 1'b0;
      bus.hzd_exe_to_id_A  = 1'b0;
      bus.hzd_mem_to_exe_A = 1'b0;
      bus.hzd_mem_to_exe_B = 1'b0;
      bus.exe_is_div       = 1'b0;
      bus.exe_br_taken     = 1'b0;

      // Reset masks every request
      cyc(1'b0, 5'b00010, Idle, "rst_div_masked");
      cyc(1'b0, 5'b01001, Idle, "rst_memA_br_masked");
      cyc(1'b1, 5'b00000, Idle, "idle");
      check_cnt(32'd0, "cnt_after_reset");

      // Single-cycle load-use on operand B
      cyc(1'b1, 5'b00100, LdStall, "memB");
      cyc(1'b1, 5'b00000, Idle, "memB_off");
      check_cnt(32'd1, "cnt_memB");

      cyc(1'b1, 5'b10001, BrFlush, "id_hzd_and_br");
      cyc(1'b1, 5'b01001, LdStall, "memA_and_br");
      cyc(1'b1, 5'b10000, IdStall, "id_hzd_only");
      cyc(1'b1, 5'b00001, BrFlush, "br_only");
      check_cnt(32'd3, "cnt_mixed");

      // Division: start at T, busy stall T+1..T+3, release T+4
      cyc(1'b1, 5'b00010, DivGo,   "div_T0");
      cyc(1'b1, 5'b00010, DivHold, "div_T1");
      cyc(1'b1, 5'b01011, DivHold, "div_T2_ignore_hzd");
      cyc(1'b1, 5'b00010, DivHold, "div_T3");
      cyc(1'b1, 5'b00010, DivRel,  "div_T4_release");
      cyc(1'b1, 5'b00000, Idle,    "div_T5_idle");
      check_cnt(32'd7, "cnt_div");

      // Reset taken at T+2 of a division
      cyc(1'b1, 5'b00010, DivGo,   "rdiv_T0");
      cyc(1'b1, 5'b00000, DivHold, "rdiv_T1");
      cyc(1'b0, 5'b00000, Idle,    "rdiv_T2_rst");
      cyc(1'b1, 5'b00000, Idle,    "rdiv_T3_run");
      check_cnt(32'd0, "cnt_rdiv");
      cyc(1'b1, 5'b00010, DivGo,   "rdiv_restart");
      cyc(1'b1, 5'b00000, DivHold, "rdiv_r1");
      cyc(1'b1, 5'b00000, DivHold, "rdiv_r2");
      cyc(1'b1, 5'b00000, DivHold, "rdiv_r3");
      cyc(1'b1, 5'b00000, DivRel,  "rdiv_r4");
      cyc(1'b1, 5'b00000, Idle,    "rdiv_r5");
      check_cnt(32'd4, "cnt_rdiv_restart");

      // Counter wrap
      @(negedge clk);
      force dut.u_perf.count_q = 32'hFFFF_FFFF;
      #1;
      release dut.u_perf.count_q;
      cyc(1'b1, 5'b00100, LdStall, "wrap_stall");
      cyc(1'b1, 5'b00000, Idle,    "wrap_idle");
      check_cnt(32'd0, "cnt_wrap");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter DIV_LAT, default 34, fixed divider latency in cycles; legal range 2..255.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port nrst  input  1  synchronous active-low reset.
REQ-004 SHALL have port hzd_exe_to_id_A  input  1  load in EXE feeds JALR base in ID.
REQ-005 SHALL have port hzd_mem_to_exe_A  input  1  load in MEM feeds EXE operand A.
REQ-006 SHALL have port hzd_mem_to_exe_B  input  1  load in MEM feeds EXE operand B.
REQ-007 SHALL have port exe_is_div  input  1  EXE holds DIV/DIVU/REM/REMU.
REQ-008 SHALL have port exe_br_taken  input  1  branch/JALR in EXE redirects PC.
REQ-009 SHALL have ports stall_if, stall_id, stall_exe  output  1 each  hold the PC, IF/ID and ID/EXE registers.
REQ-010 SHALL have ports flush_id, flush_exe, flush_mem  output  1 each  load a bubble into IF/ID, ID/EXE and EXE/MEM.
REQ-011 SHALL have port div_start  output  1  one-cycle divider launch pulse.
REQ-012 SHALL have port div_busy  output  1  high while the FSM is in DIV_BUSY.
REQ-013 SHALL have port stall_cycles  output  32  count of cycles with stall_if high.

Function
REQ-014 SHALL implement an FSM with two states: RUN and DIV_BUSY.
REQ-015 SHALL hold a down-counter cnt of width clog2(DIV_LAT).
REQ-016 In RUN with exe_is_div=1, SHALL assert div_start, stall_if/id/exe and flush_mem in the same cycle.
REQ-017 In that same case, SHALL load cnt with DIV_LAT-1 and enter DIV_BUSY.
REQ-018 In DIV_BUSY with cnt!=0, SHALL decrement cnt and assert stall_if/id/exe and flush_mem.
REQ-019 In DIV_BUSY with cnt==0, SHALL assert no stall and return to RUN. Total division stall is exactly DIV_LAT cycles.
REQ-020 SHALL never assert div_start outside RUN, so the release cycle cannot relaunch the same instruction.
REQ-021 In RUN with (hzd_mem_to_exe_A | hzd_mem_to_exe_B), SHALL assert stall_if/id/exe and flush_mem for that cycle, combinationally.
REQ-022 In RUN with hzd_exe_to_id_A, SHALL assert stall_if/id and flush_exe for that cycle, combinationally.
REQ-023 With exe_br_taken and no higher-priority condition, SHALL assert flush_id and flush_exe with no stall.
REQ-024 SHALL apply this priority, highest first:
- DIV_BUSY stall
- mem-to-EXE load-use (exe_br_taken is ignored, because branch operands are not yet valid)
- exe_br_taken (overrides hzd_exe_to_id_A, because the JALR in ID is flushed)
- hzd_exe_to_id_A
- RUN-state division start
REQ-025 SHALL never assert a stall and a flush on the same pipeline register in one cycle.
REQ-026 In the absence of any condition, SHALL drive all stall, flush and div_start outputs low.
REQ-027 SHALL increment stall_cycles on every cycle with stall_if=1; it wraps from 0xFFFFFFFF to 0.
REQ-028 SHALL ignore exe_is_div while in DIV_BUSY.

Reset
REQ-029 When nrst=0 at a rising clk edge, SHALL set state=RUN, cnt=0 and stall_cycles=0.
REQ-030 While nrst=0, SHALL hold all stall, flush, div_start and div_busy outputs low, including a reset taken mid-division.
REQ-031 After nrst deasserts, SHALL evaluate inputs normally from the first cycle.

Structure
REQ-032 SHALL place the FSM state encoding (RUN=0, DIV_BUSY=1) and the DIV_LAT default in the shared core package.
REQ-033 SHALL be a single module; the stall-cycle counter MAY be a sub-module perf_counter.

Verification
REQ-034 SHALL cover: DIV_LAT=4, exe_is_div pulsed at T -> div_start only at T, stall T..T+3, release T+4, div_busy T+1..T+4.
REQ-035 SHALL cover: hzd_mem_to_exe_B=1 for one cycle in RUN -> stall_if/id/exe=1 and flush_mem=1 for that cycle only; stall_cycles +1.
REQ-036 SHALL cover: hzd_exe_to_id_A=1 and exe_br_taken=1 together -> flush_id=flush_exe=1, all stalls 0.
REQ-037 SHALL cover: hzd_mem_to_exe_A=1 and exe_br_taken=1 together -> stall_if/id/exe=1, flush_mem=1, flush_id=flush_exe=0.
REQ-038 SHALL cover: nrst=0 at T+2 of a DIV_LAT=4 division -> from T+3 state=RUN, all outputs 0, stall_cycles=0.
REQ-039 SHALL cover: stall_cycles preloaded to 0xFFFFFFFF by force, one stall cycle -> stall_cycles=0.
